// File: rtl/fib_generator_pkg.sv
// Shared definitions for the Fibonacci write-side producer.
//   FIB_SIZE     default data/address width (matches the downstream memory)
//   fib_state_t  controller state encoding
package fib_generator_pkg;

    localparam int FIB_SIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } fib_state_t;

endpackage

// File: rtl/fib_generator_if.sv
// Request / memory-write bundle of fib_generator.
//   start, count                         request side (driven by the requester)
//   data_in, incounter, wr_en            memory write side (driven by the generator)
//   busy, done, overflow                 status (driven by the generator)
// modport master: requester / memory side; modport slave: the generator.
interface fib_generator_if
    import fib_generator_pkg::*;
#(
    parameter int SIZE = FIB_SIZE
);
    logic            start;
    logic [SIZE-1:0] count;
    logic [SIZE-1:0] data_in;
    logic [SIZE-1:0] incounter;
    logic            wr_en;
    logic            busy;
    logic            done;
    logic            overflow;

    modport master (
        output start, count,
        input  data_in, incounter, wr_en, busy, done, overflow
    );

    modport slave (
        input  start, count,
        output data_in, incounter, wr_en, busy, done, overflow
    );
endinterface

// File: rtl/fib_generator_step.sv
// fib_step: the A/B term register pair and adder.
//   clk, reset  clock and synchronous active-high reset
//   load        A <= 0, B <= 1 (start of a series)
//   advance     A <= B, B <= A + B
//   a           current term, one guard bit wider than the data path
//   ovf         guard bit of A: the current term does not fit in SIZE bits
module fib_step
    import fib_generator_pkg::*;
#(
    parameter int SIZE = FIB_SIZE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    output logic [SIZE:0] a,
    output logic          ovf
);

    logic [SIZE:0] b;

    // B may wrap once A has crossed into the guard bit; the controller
    // stops on that A before the wrapped value is ever used.
    always_ff @(posedge clk) begin
        if (reset) begin
            a <= '0;
            b <= '0;
        end else if (load) begin
            a <= '0;
            b <= (SIZE+1)'(1);
        end else if (advance) begin
            a <= b;
            b <= a + b;
        end
    end

    assign ovf = a[SIZE];

endmodule

// File: rtl/fib_generator.sv
// fib_generator: writes the Fibonacci series 0, 1, 1, 2, ... into memory.
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    fib_generator_if.slave: start/count in; data_in/incounter/wr_en,
//          busy, done (one-cycle pulse) and sticky overflow out
// A run stops after count terms, when the next term needs more than SIZE
// bits, or after the last memory address has been written.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one term written per cycle
// FIN     | done pulse, start ignored
module fib_generator
    import fib_generator_pkg::*;
#(
    parameter int SIZE = FIB_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    fib_generator_if.slave       bus
);

    localparam logic [SIZE-1:0] ADDR_MAX = '1;

    fib_state_t      state;
    fib_state_t      state_nxt;
    logic [SIZE:0]   a;
    logic            ovf;
    logic [SIZE-1:0] k;
    logic [SIZE-1:0] n;
    logic [SIZE-1:0] data_q;
    logic [SIZE-1:0] addr_q;
    logic            overflow_q;
    logic            last;
    logic            load;
    logic            write;
    logic            set_ovf;
    logic            clr_ovf;

    fib_step #(.SIZE(SIZE)) u_step (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (write),
        .a       (a),
        .ovf     (ovf)
    );

    assign last = (k == n - SIZE'(1)) || (k == ADDR_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.count != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (ovf || last) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load    = (state == ST_IDLE) && bus.start && (bus.count != '0);
        clr_ovf = (state == ST_IDLE) && bus.start;
        write   = (state == ST_RUN) && !ovf;
        set_ovf = (state == ST_RUN) && ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k          <= '0;
            n          <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (load) begin
                n <= bus.count;
                k <= '0;
            end else if (write) begin
                k      <= k + SIZE'(1);
                data_q <= a[SIZE-1:0];
                addr_q <= k;
            end
            if (clr_ovf) begin
                overflow_q <= 1'b0;
            end else if (set_ovf) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // The write is presented in the same cycle it is computed; the held
    // copies keep data/address stable between writes.
    assign bus.wr_en     = write;
    assign bus.data_in   = write ? a[SIZE-1:0] : data_q;
    assign bus.incounter = write ? k : addr_q;
    assign bus.busy      = (state == ST_RUN);
    assign bus.done      = (state == ST_FIN);
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fib_generator.sv
module tb_fib_generator;
    import fib_generator_pkg::*;

    localparam int SIZE = FIB_SIZE;
    localparam int NMAX = 1 << SIZE;

    logic clk = 1'b0;
    logic reset;

    fib_generator_if #(.SIZE(SIZE)) bus ();

    fib_generator #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // write log and stand-in memory, sampled on the falling edge
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    logic [SIZE-1:0] mem [NMAX];

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_addr.push_back(int'(bus.incounter));
            wr_data.push_back(int'(bus.data_in));
            wr_cyc.push_back(cyc);
            mem[bus.incounter] = bus.data_in;
        end
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // reference: the series itself, stopped by count, width or address space
    int mdl_terms[$];
    bit mdl_ovf;

    task automatic model_run(input int n);
        longint fa, fb, ft;
        mdl_terms.delete();
        mdl_ovf = 1'b0;
        fa = 0;
        fb = 1;
        for (int t = 0; t < n && t < NMAX; t++) begin
            if (fa >= NMAX) begin
                mdl_ovf = 1'b1;
                break;
            end
            mdl_terms.push_back(int'(fa));
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic wait_done(input string tag, input int want, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt >= want) break;
        end
        if (i == budget) chk({tag, " timeout"}, done_cnt, want);
    endtask

    int last_nwr;
    bit last_ovf;

    task automatic run_check(input string tag, input int n);
        int t_acc;
        int nw;
        clear_log();
        model_run(n);
        nw = mdl_terms.size();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.count = SIZE'(n);
        t_acc = cyc + 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.count = SIZE'($urandom);
        wait_done(tag, 1, 40);
        repeat (2) @(negedge clk);
        last_nwr = wr_addr.size();
        last_ovf = bus.overflow;
        chk($sformatf("%s nwr", tag), wr_addr.size(), nw);
        for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), wr_addr[i], i);
            chk($sformatf("%s data[%0d]", tag, i), wr_data[i], mdl_terms[i]);
            chk($sformatf("%s wcyc[%0d]", tag, i), wr_cyc[i], t_acc + i);
        end
        chk($sformatf("%s ovf", tag), int'(bus.overflow), int'(mdl_ovf));
        chk($sformatf("%s busy", tag), busy_cnt, nw + int'(mdl_ovf));
        chk($sformatf("%s done_cnt", tag), done_cnt, 1);
        chk($sformatf("%s done_cyc", tag), done_cyc, t_acc + nw + int'(mdl_ovf));
    endtask

    typedef struct {
        int count;
        int nwr;
        bit ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit found;
        int t_acc;

        tbl.push_back('{count: 5,  nwr: 5, ovf: 1'b0});
        tbl.push_back('{count: 12, nwr: 8, ovf: 1'b1});
        tbl.push_back('{count: 0,  nwr: 0, ovf: 1'b0});
        tbl.push_back('{count: 1,  nwr: 1, ovf: 1'b0});
        tbl.push_back('{count: 8,  nwr: 8, ovf: 1'b0});
        tbl.push_back('{count: 9,  nwr: 8, ovf: 1'b1});
        tbl.push_back('{count: 15, nwr: 8, ovf: 1'b1});
        tbl.push_back('{count: 2,  nwr: 2, ovf: 1'b0});
        tbl.push_back('{count: 7,  nwr: 7, ovf: 1'b0});

        reset = 1'b1;
        bus.start = 1'b1;
        bus.count = SIZE'(3);
        clear_log();
        repeat (3) @(negedge clk);
        chk("rst wr_en",     int'(bus.wr_en), 0);
        chk("rst data_in",   int'(bus.data_in), 0);
        chk("rst incounter", int'(bus.incounter), 0);
        chk("rst busy",      int'(bus.busy), 0);
        chk("rst done",      int'(bus.done), 0);
        chk("rst overflow",  int'(bus.overflow), 0);
        bus.start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            run_check($sformatf("tbl%0d_n%0d", i, tbl[i].count), tbl[i].count);
            chk($sformatf("tbl%0d nwr_const", i), last_nwr, tbl[i].nwr);
            chk($sformatf("tbl%0d ovf_const", i), int'(last_ovf), int'(tbl[i].ovf));
        end

        // overflow is sticky in IDLE and the last write is held
        run_check("ovf12", 12);
        repeat (3) @(negedge clk);
        chk("sticky overflow",  int'(bus.overflow), 1);
        chk("hold data_in",     int'(bus.data_in), 13);
        chk("hold incounter",   int'(bus.incounter), 7);
        chk("idle wr_en",       int'(bus.wr_en), 0);
        run_check("zero_clr", 0);
        chk("zero clears ovf",  int'(bus.overflow), 0);

        // reset during the third write of a six-term run
        clear_log();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.count = SIZE'(6);
        @(posedge clk); #1;
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.wr_en === 1'b1 && bus.incounter == SIZE'(2)) begin
                found = 1'b1;
                break;
            end
        end
        chk("midrst third write seen", int'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst wr_en",     int'(bus.wr_en), 0);
        chk("midrst data_in",   int'(bus.data_in), 0);
        chk("midrst incounter", int'(bus.incounter), 0);
        chk("midrst busy",      int'(bus.busy), 0);
        chk("midrst done",      int'(bus.done), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst no done",   done_cnt, 0);
        chk("midrst writes",    wr_addr.size(), 3);
        run_check("after_rst", 2);

        // start held high through back-to-back four-term runs
        clear_log();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.count = SIZE'(4);
        t_acc = cyc + 1;
        wait_done("held", 2, 60);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        model_run(4);
        chk("held nwr",  wr_addr.size(), 8);
        chk("held done", done_cnt, 2);
        chk("held busy", busy_cnt, 8);
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            chk($sformatf("held addr[%0d]", i), wr_addr[i], i % 4);
            chk($sformatf("held data[%0d]", i), wr_data[i], mdl_terms[i % 4]);
            chk($sformatf("held wcyc[%0d]", i), wr_cyc[i],
                t_acc + ((i < 4) ? i : i + 2));
        end

        // six terms into memory, then read back addresses 0..5
        run_check("mem6", 6);
        model_run(6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("mem[%0d]", i), int'(mem[i]), mdl_terms[i]);
        end

        for (int r = 0; r < 24; r++) begin
            int n;
            n = int'($urandom_range(0, NMAX - 1));
            run_check($sformatf("rnd%0d_n%0d", r, n), n);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
